sobel_mag: RTL and testbench



---
 rtl/sobel_mag.sv | 63 ++++++
 tb/tb_sobel_mag.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sobel_mag.sv
// sobel_mag: pipelined Sobel gradient magnitude for one 3x3 greyscale window.
// The centre pixel is not used. Output is the L1 norm |Gx| + |Gy|, saturated to 8 bits.
//   clk    : rising-edge clock for all state
//   rst_n  : synchronous active-low reset; clears both pipeline stages
//   p0..p8 : window pixels (p4 / centre not present), unsigned 8-bit
//   magval : registered edge magnitude, 0..255
// Pipeline: stage 1 registers |Gx| and |Gy|, stage 2 registers the saturated sum.
// A new window is accepted every clock. There is no stall.
module sobel_mag (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] p0,
    input  logic [7:0] p1,
    input  logic [7:0] p2,
    input  logic [7:0] p3,
    input  logic [7:0] p5,
    input  logic [7:0] p6,
    input  logic [7:0] p7,
    input  logic [7:0] p8,
    output logic [7:0] magval
);

    // Each weighted column/row sum is at most 4*255 = 1020, so it fits in 10 bits unsigned.
    logic [9:0] sum_right, sum_left, sum_bot, sum_top;
    logic signed [10:0] gx, gy;
    logic [9:0] abs_gx, abs_gy;

    always_comb begin
        sum_right = {2'b00, p2} + {1'b0, p5, 1'b0} + {2'b00, p8};
        sum_left  = {2'b00, p0} + {1'b0, p3, 1'b0} + {2'b00, p6};
        sum_bot   = {2'b00, p6} + {1'b0, p7, 1'b0} + {2'b00, p8};
        sum_top   = {2'b00, p0} + {1'b0, p1, 1'b0} + {2'b00, p2};
        gx = signed'({1'b0, sum_right}) - signed'({1'b0, sum_left});
        gy = signed'({1'b0, sum_bot})   - signed'({1'b0, sum_top});
        // |G| <= 1020, so the 10-bit truncation of the negated value is exact.
        abs_gx = gx[10] ? 10'(-gx) : gx[9:0];
        abs_gy = gy[10] ? 10'(-gy) : gy[9:0];
    end

    logic [9:0]  abs_gx_q, abs_gy_q;
    logic [10:0] mag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            abs_gx_q <= '0;
            abs_gy_q <= '0;
        end else begin
            abs_gx_q <= abs_gx;
            abs_gy_q <= abs_gy;
        end
    end

    // 11-bit sum holds the full 0..2040 range, so the saturation compare never sees a wrapped value.
    always_comb mag = {1'b0, abs_gx_q} + {1'b0, abs_gy_q};

    always_ff @(posedge clk) begin
        if (!rst_n)
            magval <= '0;
        else
            magval <= (mag > 11'd255) ? 8'hFF : mag[7:0];
    end

endmodule

// File: tb/tb_sobel_mag.sv
// tb_sobel_mag: self-checking bench for sobel_mag.
// The bench uses a table of directed windows with their expected magnitudes, a hand-written
// mid-stream reset sequence, and randomized windows with occasional resets. All checks are
// compared against a plain-arithmetic Sobel reference. A window driven before edge N is
// visible on magval after edge N+1.
module tb_sobel_mag;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] p0, p1, p2, p3, p5, p6, p7, p8;
    logic [7:0] magval;

    sobel_mag dut (
        .clk(clk), .rst_n(rst_n),
        .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p5(p5), .p6(p6), .p7(p7), .p8(p8),
        .magval(magval)
    );

    always #5 clk = ~clk;

    typedef logic [8:0][7:0] win_t;   // index = pixel number, [4] unused
    typedef struct {
        win_t       w;
        logic [7:0] exp;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [7:0] pend;   // reference result of the window sampled at the last edge

    function automatic win_t mk(int a0, int a1, int a2, int a3, int a5, int a6, int a7, int a8);
        win_t w;
        w = '0;
        w[0] = 8'(a0); w[1] = 8'(a1); w[2] = 8'(a2); w[3] = 8'(a3);
        w[5] = 8'(a5); w[6] = 8'(a6); w[7] = 8'(a7); w[8] = 8'(a8);
        return w;
    endfunction

    function automatic logic [7:0] ref_mag(win_t w);
        int gx, gy, m;
        gx = (int'(w[2]) + 2*int'(w[5]) + int'(w[8])) - (int'(w[0]) + 2*int'(w[3]) + int'(w[6]));
        gy = (int'(w[6]) + 2*int'(w[7]) + int'(w[8])) - (int'(w[0]) + 2*int'(w[1]) + int'(w[2]));
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return (m > 255) ? 8'd255 : 8'(m);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one window and reset level. Let one edge pass, then compare with the reference.
    task automatic cycle(input win_t w, input logic r);
        logic [7:0] exp;
        p0 = w[0]; p1 = w[1]; p2 = w[2]; p3 = w[3];
        p5 = w[5]; p6 = w[6]; p7 = w[7]; p8 = w[8];
        rst_n = r;
        @(posedge clk);
        #1;
        if (!r) begin
            exp  = 8'd0;
            pend = 8'd0;
        end else begin
            exp  = pend;
            pend = ref_mag(w);
        end
        check("model", magval, exp);
    endtask

    vec_t tbl[$];

    initial begin
        win_t w;
        pend = 8'd0;

        tbl.push_back('{mk(100,100,100,100,100,100,100,100), 8'd0});
        tbl.push_back('{mk(0,5,10,0,10,0,5,10),              8'd40});
        tbl.push_back('{mk(10,5,0,10,0,10,5,0),              8'd40});
        tbl.push_back('{mk(20,20,20,25,25,30,30,30),         8'd40});
        tbl.push_back('{mk(0,0,0,0,0,0,0,10),                8'd20});
        tbl.push_back('{mk(255,0,0,0,0,0,0,0),               8'd255});
        tbl.push_back('{mk(0,0,64,0,64,0,0,64),              8'd255});
        tbl.push_back('{mk(0,0,1,0,63,0,0,0),                8'd128});
        tbl.push_back('{mk(0,0,1,0,126,0,0,1),               8'd254});  // mag 254
        tbl.push_back('{mk(0,0,0,0,127,0,0,1),               8'd255});  // mag 256
        tbl.push_back('{mk(0,0,255,0,255,255,255,255),       8'd255});  // mag 1530
        tbl.push_back('{mk(0,0,0,0,0,0,0,0),                 8'd0});

        // Reset for two edges. The output must then read zero.
        cycle(mk(0,0,0,0,0,0,0,0), 1'b0);
        cycle(mk(9,9,9,9,9,9,9,9), 1'b0);
        check("reset", magval, 8'd0);

        // Table vectors are streamed back to back. The output after edge i belongs to vector i-1.
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].w, 1'b1);
            if (i > 0) check("vec", magval, tbl[i-1].exp);
        end
        cycle(mk(0,0,0,0,0,0,0,0), 1'b1);
        check("vec_last", magval, tbl[tbl.size()-1].exp);

        // Apply a one-cycle reset mid-stream. The window in flight and the window at the reset edge are dropped.
        cycle(mk(255,0,0,0,0,0,0,0), 1'b1);          // would give 255
        cycle(mk(0,5,10,0,10,0,5,10), 1'b0);         // reset edge, window dropped
        check("rst_edge", magval, 8'd0);
        cycle(mk(0,0,0,0,0,0,0,10), 1'b1);           // first edge out of reset
        check("rst_next", magval, 8'd0);
        cycle(mk(100,100,100,100,100,100,100,100), 1'b1);
        check("post_rst", magval, 8'd20);
        cycle(mk(0,0,0,0,0,0,0,0), 1'b1);
        check("post_rst2", magval, 8'd0);

        // Apply random windows with occasional resets. Half of them use small values to stay below saturation.
        for (int n = 0; n < 400; n++) begin
            int hi;
            w = '0;
            hi = ($urandom_range(0, 1) == 0) ? 20 : 255;
            for (int j = 0; j < 9; j++) w[j] = 8'($urandom_range(0, hi));
            cycle(w, ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Backstop so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
